// File: rtl/clk_divider_mc.sv
`default_nettype none
// ============================================================================
// Module      : clk_divider_mc
// Description : Multi-channel programmable clock divider. Each channel
//               produces a 50% duty square wave of period 2*(act+1) clk
//               cycles. A new half-period is staged in a shadow register and
//               becomes active only at a half-period boundary, so no output
//               half-period is ever truncated. sync restarts every channel
//               phase-aligned.
//               Optional feature macro: CLK_DIVIDER_MC_TICK_EN adds the tick
//               output (one-cycle pulse marking each rising edge of clk_out).
// Ports       : clk      - single clock, rising edge
//               rst      - synchronous active-high reset
//               en       - per-channel count enable        [NCH]
//               half_in  - per-channel half-period values  [NCH*CW]
//               load     - per-channel shadow-load strobe  [NCH]
//               sync     - restart all channels phase-aligned
//               clk_out  - registered divided clocks       [NCH]
//               pend     - shadow value waiting to apply   [NCH]
//               tick     - rising-edge pulse (macro only)  [NCH]
// Revision    : 1.0 - initial release
// ============================================================================
module clk_divider_mc #(
    parameter int NCH          = 2,
    parameter int CW           = 16,
    parameter int DEFAULT_HALF = 49999
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      en,
    input  logic [NCH*CW-1:0]   half_in,
    input  logic [NCH-1:0]      load,
    input  logic                sync,
    output logic [NCH-1:0]      clk_out,
    output logic [NCH-1:0]      pend
`ifdef CLK_DIVIDER_MC_TICK_EN
    ,
    output logic [NCH-1:0]      tick
`endif
);

    localparam logic [CW-1:0] c_default_half = CW'(DEFAULT_HALF);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] r_act;
        logic [CW-1:0] r_shd;
        logic          r_out;
        logic          r_pend;
        logic [CW-1:0] w_half;
        logic          w_term;
`ifdef CLK_DIVIDER_MC_TICK_EN
        logic          r_tick;
`endif

        assign w_half = half_in[i*CW +: CW];
        // Last cycle of the current half-period.
        assign w_term = en[i] && (r_cnt == r_act);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt  <= '0;
                r_act  <= c_default_half;
                r_shd  <= c_default_half;
                r_out  <= 1'b0;
                r_pend <= 1'b0;
`ifdef CLK_DIVIDER_MC_TICK_EN
                r_tick <= 1'b0;
`endif
            end else if (sync) begin
                // Restart: a load arriving with sync takes effect directly,
                // otherwise any staged value is applied now.
                r_cnt  <= '0;
                r_out  <= 1'b0;
                r_pend <= 1'b0;
`ifdef CLK_DIVIDER_MC_TICK_EN
                r_tick <= 1'b0;
`endif
                if (load[i]) begin
                    r_act <= w_half;
                    r_shd <= w_half;
                end else if (r_pend) begin
                    r_act <= r_shd;
                end
            end else begin
`ifdef CLK_DIVIDER_MC_TICK_EN
                r_tick <= w_term && !r_out;
`endif
                if (w_term) begin
                    r_out <= ~r_out;
                    r_cnt <= '0;
                    // Old shadow is applied even if a new load lands on
                    // this same edge; the new value stays pending.
                    if (r_pend) begin
                        r_act <= r_shd;
                    end
                end else if (en[i]) begin
                    r_cnt <= r_cnt + CW'(1);
                end

                if (load[i]) begin
                    r_shd  <= w_half;
                    r_pend <= 1'b1;
                end else if (w_term && r_pend) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign clk_out[i] = r_out;
        assign pend[i]    = r_pend;
`ifdef CLK_DIVIDER_MC_TICK_EN
        assign tick[i]    = r_tick;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_divider_mc
// Description : Self-checking bench for clk_divider_mc (NCH=2, CW=8,
//               DEFAULT_HALF=3). Directed scenarios plus randomized traffic
//               checked against a remaining-cycles reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_divider_mc;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int DH  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              sync;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    load;
    logic [NCH*CW-1:0] half_in;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: half-period length, staged value, cycles remaining
    // in the current half-period.
    int             m_half [NCH];
    int             m_nxt  [NCH];
    int             m_rem  [NCH];
    logic [NCH-1:0] exp_out;
    logic [NCH-1:0] exp_pend;
    logic [NCH-1:0] exp_tick;

    always #5 clk = ~clk;

    clk_divider_mc #(
        .NCH          (NCH),
        .CW           (CW),
        .DEFAULT_HALF (DH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .half_in (half_in),
        .load    (load),
        .sync    (sync),
        .clk_out (clk_out),
        .pend    (pend)
`ifdef CLK_DIVIDER_MC_TICK_EN
        ,
        .tick    (tick)
`endif
    );

`ifndef CLK_DIVIDER_MC_TICK_EN
    assign tick = '0;
`endif

    // Advance one clock edge, update the model from the inputs seen at that
    // edge, then settle so outputs can be sampled.
    task automatic cycle();
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            int hin;
            hin = int'(half_in[c*CW +: CW]);
            if (rst) begin
                m_half[c] = DH; m_nxt[c] = DH; m_rem[c] = DH;
                exp_pend[c] = 1'b0; exp_out[c] = 1'b0; exp_tick[c] = 1'b0;
            end else if (sync) begin
                if (load[c]) m_half[c] = hin;
                else if (exp_pend[c]) m_half[c] = m_nxt[c];
                if (load[c]) m_nxt[c] = hin;
                m_rem[c] = m_half[c];
                exp_pend[c] = 1'b0; exp_out[c] = 1'b0; exp_tick[c] = 1'b0;
            end else begin
                exp_tick[c] = 1'b0;
                if (en[c]) begin
                    if (m_rem[c] == 0) begin
                        exp_tick[c] = !exp_out[c];
                        exp_out[c]  = !exp_out[c];
                        if (exp_pend[c]) begin
                            m_half[c]   = m_nxt[c];
                            exp_pend[c] = 1'b0;
                        end
                        m_rem[c] = m_half[c];
                    end else begin
                        m_rem[c]--;
                    end
                end
                if (load[c]) begin
                    m_nxt[c]    = hin;
                    exp_pend[c] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sync = 1'b0; load = '0; en = '0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sync = 1'b0; load = '0; en = '0; half_in = '0;
        cycle(); cycle();
        rst = 1'b0;
        n_tests++;
        if (clk_out !== 2'b00) begin n_fail++; $display("FAIL reset_clk_out got %b want 00", clk_out); end
        n_tests++;
        if (pend !== 2'b00) begin n_fail++; $display("FAIL reset_pend got %b want 00", pend); end
`ifdef CLK_DIVIDER_MC_TICK_EN
        n_tests++;
        if (tick !== 2'b00) begin n_fail++; $display("FAIL reset_tick got %b want 00", tick); end
`endif
    endtask

    task automatic test_basic();
        logic [1:0] eo, et;
        en = 2'b11;
        for (int e = 1; e <= 16; e++) begin
            cycle();
            eo = ((e / 4) % 2 == 1) ? 2'b11 : 2'b00;
            et = (e % 8 == 4) ? 2'b11 : 2'b00;
            n_tests++;
            if (clk_out !== eo) begin n_fail++; $display("FAIL basic_clk_out edge %0d got %b want %b", e, clk_out, eo); end
`ifdef CLK_DIVIDER_MC_TICK_EN
            n_tests++;
            if (tick !== et) begin n_fail++; $display("FAIL basic_tick edge %0d got %b want %b", e, tick, et); end
`endif
        end
    endtask

    task automatic test_reload();
        logic       lvl, seen;
        logic [1:0] prev;
        int         last[NCH];
        int         per[NCH];
        cycle();
        half_in = {8'd9, 8'd1};
        load = 2'b01;
        cycle();
        load = 2'b00;
        n_tests++;
        if (pend !== 2'b01) begin n_fail++; $display("FAIL reload_pend_set got %b want 01", pend); end
        lvl = clk_out[0]; seen = 1'b0; prev = clk_out;
        for (int c = 0; c < NCH; c++) begin last[c] = -1; per[c] = 0; end
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (clk_out[0] !== lvl) seen = 1'b1;
            n_tests++;
            if (pend[0] !== !seen) begin n_fail++; $display("FAIL reload_pend cycle %0d got %b want %b", k, pend[0], !seen); end
            n_tests++;
            if (clk_out !== exp_out) begin n_fail++; $display("FAIL reload_model cycle %0d got %b want %b", k, clk_out, exp_out); end
            for (int c = 0; c < NCH; c++) begin
                if (clk_out[c] && !prev[c]) begin
                    if (last[c] >= 0) per[c] = k - last[c];
                    last[c] = k;
                end
            end
            prev = clk_out;
        end
        n_tests++;
        if (per[0] != 4) begin n_fail++; $display("FAIL reload_period_ch0 got %0d want 4", per[0]); end
        n_tests++;
        if (per[1] != 8) begin n_fail++; $display("FAIL reload_period_ch1 got %0d want 8", per[1]); end
    endtask

    task automatic test_coincide();
        int   n;
        logic lvl;
        do_reset();
        en = 2'b01;
        half_in = {8'd0, 8'd2}; load = 2'b01; cycle(); load = 2'b00;
        n = 0; while (exp_pend[0] && n < 20) begin cycle(); n++; end
        n = 0; while (m_rem[0] != 1 && n < 20) begin cycle(); n++; end
        half_in = {8'd0, 8'd3}; load = 2'b01; cycle(); load = 2'b00;
        half_in = {8'd0, 8'd5}; load = 2'b01; cycle(); load = 2'b00;
        n_tests++;
        if (pend[0] !== 1'b1) begin n_fail++; $display("FAIL coincide_pend_kept got %b want 1", pend[0]); end
        lvl = clk_out[0]; n = 0;
        do begin cycle(); n++; end while (clk_out[0] === lvl && n < 20);
        n_tests++;
        if (n != 4) begin n_fail++; $display("FAIL coincide_half_old got %0d want 4", n); end
        n_tests++;
        if (pend[0] !== 1'b0) begin n_fail++; $display("FAIL coincide_pend_clear got %b want 0", pend[0]); end
        lvl = clk_out[0]; n = 0;
        do begin cycle(); n++; end while (clk_out[0] === lvl && n < 20);
        n_tests++;
        if (n != 6) begin n_fail++; $display("FAIL coincide_half_new got %0d want 6", n); end
    endtask

    task automatic test_enable_hold();
        logic held;
        do_reset();
        en = 2'b11;
        for (int k = 0; k < 6; k++) cycle();
        en = 2'b01;
        held = clk_out[1];
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_tests++;
            if (clk_out[1] !== held) begin n_fail++; $display("FAIL hold_clk_out cycle %0d got %b want %b", k, clk_out[1], held); end
`ifdef CLK_DIVIDER_MC_TICK_EN
            n_tests++;
            if (tick[1] !== 1'b0) begin n_fail++; $display("FAIL hold_tick cycle %0d got %b want 0", k, tick[1]); end
`endif
        end
        en = 2'b11;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_tests++;
            if (clk_out !== exp_out) begin n_fail++; $display("FAIL hold_resume cycle %0d got %b want %b", k, clk_out, exp_out); end
        end
    endtask

    task automatic test_sync();
        logic [1:0] eo;
        do_reset();
        en = 2'b01;
        for (int k = 0; k < 3; k++) cycle();
        en = 2'b11;
        for (int k = 0; k < 2; k++) cycle();
        sync = 1'b1; load = 2'b01; half_in = {8'd7, 8'd0};
        cycle();
        sync = 1'b0; load = 2'b00;
        n_tests++;
        if (clk_out !== 2'b00) begin n_fail++; $display("FAIL sync_clk_out got %b want 00", clk_out); end
        n_tests++;
        if (pend !== 2'b00) begin n_fail++; $display("FAIL sync_pend got %b want 00", pend); end
        for (int k = 1; k <= 8; k++) begin
            cycle();
            eo[0] = (k % 2 == 1);
            eo[1] = (k >= 4 && k < 8);
            n_tests++;
            if (clk_out !== eo) begin n_fail++; $display("FAIL sync_align edge %0d got %b want %b", k, clk_out, eo); end
        end
    endtask

    task automatic test_rst_during();
        logic [1:0] eo;
        en = 2'b11; half_in = {8'd1, 8'd2}; load = 2'b11;
        cycle();
        rst = 1'b1; sync = 1'b1; load = 2'b11; half_in = {8'd0, 8'd0};
        cycle();
        rst = 1'b0; sync = 1'b0; load = 2'b00;
        n_tests++;
        if (clk_out !== 2'b00) begin n_fail++; $display("FAIL rstsync_clk_out got %b want 00", clk_out); end
        n_tests++;
        if (pend !== 2'b00) begin n_fail++; $display("FAIL rstsync_pend got %b want 00", pend); end
`ifdef CLK_DIVIDER_MC_TICK_EN
        n_tests++;
        if (tick !== 2'b00) begin n_fail++; $display("FAIL rstsync_tick got %b want 00", tick); end
`endif
        for (int e = 1; e <= 4; e++) begin
            cycle();
            eo = (e == 4) ? 2'b11 : 2'b00;
            n_tests++;
            if (clk_out !== eo) begin n_fail++; $display("FAIL rstsync_first_rise edge %0d got %b want %b", e, clk_out, eo); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            rst  = ($urandom_range(0, 99) == 0);
            sync = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NCH; c++) begin
                load[c] = ($urandom_range(0, 5) == 0);
                en[c]   = ($urandom_range(0, 4) != 0);
                half_in[c*CW +: CW] = CW'($urandom_range(0, 6));
            end
            cycle();
            n_tests++;
            if (clk_out !== exp_out) begin n_fail++; $display("FAIL rand_clk_out cycle %0d got %b want %b", k, clk_out, exp_out); end
            n_tests++;
            if (pend !== exp_pend) begin n_fail++; $display("FAIL rand_pend cycle %0d got %b want %b", k, pend, exp_pend); end
`ifdef CLK_DIVIDER_MC_TICK_EN
            n_tests++;
            if (tick !== exp_tick) begin n_fail++; $display("FAIL rand_tick cycle %0d got %b want %b", k, tick, exp_tick); end
`endif
        end
        rst = 1'b0; sync = 1'b0; load = '0;
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; en = '0; load = '0; half_in = '0;
        exp_out = '0; exp_pend = '0; exp_tick = '0;
        for (int c = 0; c < NCH; c++) begin
            m_half[c] = DH; m_nxt[c] = DH; m_rem[c] = DH;
        end
        test_reset();
        test_basic();
        test_reload();
        test_coincide();
        test_enable_hold();
        test_sync();
        test_rst_during();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_divider_mc.md
CLK_DIVIDER_MC -- requirements
Module: clk_divider_mc

Interface
REQ-001 The block SHALL have parameter NCH, default 2: number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CW, default 16: per-channel counter and half-period width in bits.
REQ-003 The block SHALL have parameter DEFAULT_HALF, default 49999: reset half-period value; it must be less than 2^CW.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, NCH bits: per-channel count enable.
REQ-007 The block SHALL have port half_in, input, NCH*CW bits: per-channel new half-period value; channel i uses bits [i*CW +: CW].
REQ-008 The block SHALL have port load, input, NCH bits: per-channel strobe that captures half_in into the channel's shadow register.
REQ-009 The block SHALL have port sync, input, 1 bit: restarts all channels phase-aligned.
REQ-010 The block SHALL have port clk_out, output, NCH bits: registered divided square waves.
REQ-011 The block SHALL have port pend, output, NCH bits: a shadow value is waiting to become active.
REQ-012 The block SHALL have port tick, output, NCH bits: registered one-cycle pulse per channel (present only with the configuration macro).

Function
REQ-013 Each channel SHALL hold a CW-bit counter cnt, an active half-period act, and a shadow half-period shd.
REQ-014 With en[i]=1 and cnt==act, the channel SHALL toggle clk_out[i] and clear cnt; otherwise it SHALL increment cnt by 1.
REQ-015 Output period SHALL be 2*(act+1) clk cycles with 50% duty; act=0 SHALL give clk/2.
REQ-016 With en[i]=0, cnt and clk_out[i] SHALL hold, and tick[i] SHALL be 0.
REQ-017 load[i]=1 SHALL write half_in slice i into shd and set pend[i] on the next edge, regardless of en[i].
REQ-018 On a terminal cycle (en[i]=1, cnt==act) with pend[i]=1, act SHALL take shd and pend[i] SHALL clear, so the new period starts at a half-period boundary without truncating the current half-period.
REQ-019 When load[i] and a terminal cycle coincide, shd SHALL take the new value, the previous shd SHALL be applied to act, and pend[i] SHALL remain 1.
REQ-020 sync=1 SHALL, on the next edge, clear every cnt and clk_out and clear every pend.
REQ-021 On that edge, act SHALL take half_in if load[i]=1, else shd if pend[i]=1, else keep its value.
REQ-022 sync SHALL take priority over en and over the terminal-count update.
REQ-023 tick[i] SHALL be 1 exactly in the first cycle clk_out[i] is 1 after a 0->1 toggle, and 0 otherwise.
REQ-024 cnt SHALL never exceed act; no wrap beyond 2^CW-1 can occur.
REQ-025 Channels SHALL be fully independent except for the shared sync.

Reset
REQ-026 When rst=1 at a clk edge, every cnt SHALL become 0, clk_out 0, tick 0, pend 0, and act and shd DEFAULT_HALF.
REQ-027 rst SHALL override sync, load and en; a reset mid-period SHALL discard partial counts and pending loads.
REQ-028 The first clk_out rise after rst release with en=1 SHALL occur DEFAULT_HALF+1 edges after the first non-reset edge.

Configuration
REQ-029 With macro CLK_DIVIDER_MC_TICK_EN defined, the tick output and its register SHALL be present and behave per REQ-023.
REQ-030 Without CLK_DIVIDER_MC_TICK_EN, the tick port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
(Parameters for all scenarios: NCH=2, CW=8, DEFAULT_HALF=3, macro defined.)
REQ-031 Reset then en=2'b11 -> both clk_out rise on edge 4, fall on edge 8, period 8; tick pulses one cycle at each rise.
REQ-032 Channel 0: half_in=1 and load pulsed mid-half-period -> pend[0]=1 until the current half-period ends, then period 4; channel 1 remains period 8.
REQ-033 load coinciding with a terminal cycle, old shd=3, new=5 -> act becomes 3, pend stays 1, and 5 is applied at the next terminal.
REQ-034 en[1]=0 for 10 cycles mid-count -> clk_out[1] frozen with no tick; count resumes from the held cnt.
REQ-035 Channels at different phases, sync=1 with load[0]=1 and half_in0=0 -> both clk_out=0 and cnt=0; ch0 then toggles every cycle; ch1 rises 4 edges later.
REQ-036 rst asserted during sync and load -> all reset values per REQ-026 and pend=0.
